// File: rtl/basketball_game_ctrl.sv
// basketball_game_ctrl
// Game-level sequencer that sits above the 24 s shot-clock block. It owns the
// period clock (mm:ss in BCD), the quarter count and the horn, and turns the
// referee's start / whistle / possession pulses into reload and hold requests
// for the shot clock. It also blanks the shot clock when less game time than
// shot time remains.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse, start or resume play
//   whistle             one-cycle pulse, stop play (beats start in the same cycle)
//   possession          one-cycle pulse, possession change
//   shot_expired        shot clock alarm level (high = shot clock at 0)
//   shot_h, shot_l      shot clock digits, BCD
//   shot_rst            reload request to the shot clock (high = reload 24)
//   shot_pause          hold request to the shot clock
//   run                 game clock running
//   min_h..sec_l        period clock digits, BCD
//   quarter             current period, 1..NUM_QTR
//   horn                end-of-period / violation horn
//   shot_off            shot clock display should be blanked
module basketball_game_ctrl #(
  parameter int CLK_DIV  = 50000000,
  parameter int QTR_MIN  = 12,
  parameter int NUM_QTR  = 4,
  parameter int HORN_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       whistle,
  input  logic       possession,
  input  logic       shot_expired,
  input  logic [3:0] shot_h,
  input  logic [3:0] shot_l,
  output logic       shot_rst,
  output logic       shot_pause,
  output logic       run,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic [2:0] quarter,
  output logic       horn,
  output logic       shot_off
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HORN_LEN + 1);
  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HORN_RELOAD = HW'(HORN_LEN - 1);
  localparam logic [3:0]    QTR_TENS    = 4'(QTR_MIN / 10);
  localparam logic [3:0]    QTR_ONES    = 4'(QTR_MIN % 10);
  localparam logic [2:0]    LAST_QTR    = 3'(NUM_QTR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP,
    ST_BREAK,
    ST_FINAL
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [HW-1:0] horn_cnt;

  logic       tick;
  logic       last_sec;
  logic       go;
  logic       poss_ok;
  logic       horn_trig;
  logic [3:0] dec_min_h;
  logic [3:0] dec_min_l;
  logic [3:0] dec_sec_h;
  logic [3:0] dec_sec_l;

  // Decode helpers shared by the FSM and the horn. A whistle in the same
  // cycle as start cancels the start. The BCD decrement borrows digit by
  // digit; it is never applied at 00:00 because the 00:01 tick leaves RUN.
  always_comb begin
    tick      = (presc == PRESC_MAX);
    last_sec  = (min_h == 4'd0) && (min_l == 4'd0) && (sec_h == 4'd0) && (sec_l == 4'd1);
    go        = start && !whistle;
    poss_ok   = possession && ((state == ST_RUN) || (state == ST_STOP) || (state == ST_BREAK));
    horn_trig = (state == ST_RUN) && (shot_expired || (tick && last_sec));

    dec_min_h = min_h;
    dec_min_l = min_l;
    dec_sec_h = sec_h;
    dec_sec_l = sec_l - 4'd1;
    if (sec_l == 4'd0) begin
      dec_sec_l = 4'd9;
      if (sec_h == 4'd0) begin
        dec_sec_h = 4'd5;
        if (min_l == 4'd0) begin
          dec_min_l = 4'd9;
          dec_min_h = min_h - 4'd1;
        end else begin
          dec_min_l = min_l - 4'd1;
        end
      end else begin
        dec_sec_h = sec_h - 4'd1;
      end
    end
  end

  // Game FSM. run / shot_pause / shot_rst are written alongside the state so
  // they change on the same edge as the transition. In RUN the prescaler
  // advances on every edge, including the one that leaves RUN; the period-end
  // tick outranks whistle and shot expiry so only one horn is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      presc      <= '0;
      quarter    <= 3'd1;
      min_h      <= QTR_TENS;
      min_l      <= QTR_ONES;
      sec_h      <= 4'd0;
      sec_l      <= 4'd0;
      run        <= 1'b0;
      shot_pause <= 1'b1;
      shot_rst   <= 1'b1;
    end else begin
      shot_rst <= poss_ok;
      case (state)
        ST_IDLE: begin
          shot_rst <= 1'b1;
          if (go) begin
            state      <= ST_RUN;
            run        <= 1'b1;
            shot_pause <= 1'b0;
            shot_rst   <= 1'b0;
          end
        end

        ST_RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            min_h <= dec_min_h;
            min_l <= dec_min_l;
            sec_h <= dec_sec_h;
            sec_l <= dec_sec_l;
          end
          if (tick && last_sec) begin
            run        <= 1'b0;
            shot_pause <= 1'b1;
            if (quarter < LAST_QTR) begin
              state <= ST_BREAK;
            end else begin
              state    <= ST_FINAL;
              shot_rst <= 1'b1;
            end
          end else if (whistle || shot_expired) begin
            state      <= ST_STOP;
            run        <= 1'b0;
            shot_pause <= 1'b1;
          end
        end

        // The prescaler is left untouched here so a fractional second survives.
        ST_STOP: begin
          if (go) begin
            state      <= ST_RUN;
            run        <= 1'b1;
            shot_pause <= 1'b0;
          end
        end

        ST_BREAK: begin
          if (go) begin
            state      <= ST_RUN;
            quarter    <= quarter + 3'd1;
            min_h      <= QTR_TENS;
            min_l      <= QTR_ONES;
            sec_h      <= 4'd0;
            sec_l      <= 4'd0;
            presc      <= '0;
            run        <= 1'b1;
            shot_pause <= 1'b0;
            shot_rst   <= 1'b1;
          end
        end

        ST_FINAL: begin
          shot_rst <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Horn timer: horn_cnt holds the cycles still to come after the current
  // one, so a trigger yields exactly HORN_LEN high cycles. A retrigger while
  // sounding simply reloads the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      horn     <= 1'b0;
      horn_cnt <= '0;
    end else if (horn_trig) begin
      horn     <= 1'b1;
      horn_cnt <= HORN_RELOAD;
    end else if (horn_cnt != '0) begin
      horn_cnt <= horn_cnt - HW'(1);
    end else begin
      horn <= 1'b0;
    end
  end

  // Blank the shot clock once the game time left is under the shot time.
  // Concatenated BCD digits compare in the same order as the values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shot_off <= 1'b0;
    end else begin
      shot_off <= (min_h == 4'd0) && (min_l == 4'd0) && ({sec_h, sec_l} < {shot_h, shot_l});
    end
  end

endmodule

// File: tb/tb_basketball_game_ctrl.sv
// tb_basketball_game_ctrl
// Self-checking bench for basketball_game_ctrl with a 4-cycle game second,
// 1-minute periods, 2 periods and an 8-cycle horn. A directed vector table
// walks the main game flow, a few hand-built vectors cover shot_off and
// reset, and a randomized phase is compared against a time-in-seconds model.
module tb_basketball_game_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int QTR_MIN  = 1;
  localparam int NUM_QTR  = 2;
  localparam int HORN_LEN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       whistle;
  logic       possession;
  logic       shot_expired;
  logic [3:0] shot_h;
  logic [3:0] shot_l;
  logic       shot_rst;
  logic       shot_pause;
  logic       run;
  logic [3:0] min_h;
  logic [3:0] min_l;
  logic [3:0] sec_h;
  logic [3:0] sec_l;
  logic [2:0] quarter;
  logic       horn;
  logic       shot_off;

  int checks_total  = 0;
  int checks_passed = 0;

  basketball_game_ctrl #(
    .CLK_DIV (CLK_DIV),
    .QTR_MIN (QTR_MIN),
    .NUM_QTR (NUM_QTR),
    .HORN_LEN(HORN_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .whistle     (whistle),
    .possession  (possession),
    .shot_expired(shot_expired),
    .shot_h      (shot_h),
    .shot_l      (shot_l),
    .shot_rst    (shot_rst),
    .shot_pause  (shot_pause),
    .run         (run),
    .min_h       (min_h),
    .min_l       (min_l),
    .sec_h       (sec_h),
    .sec_l       (sec_l),
    .quarter     (quarter),
    .horn        (horn),
    .shot_off    (shot_off)
  );

  always #5 clk = ~clk;

  // One directed step: inputs held for the first edge (pulses dropped after
  // it, shot digits kept), then wait_cycles more edges, then compare.
  typedef struct {
    logic       rst;
    logic       start;
    logic       whistle;
    logic       poss;
    logic       expired;
    logic [3:0] sh;
    logic [3:0] sl;
    int         wait_cycles;
    logic       e_run;
    logic       e_pause;
    logic       e_srst;
    logic       e_horn;
    logic       e_off;
    int         e_q;
    int         e_secs;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: game time as whole seconds plus cycles into the second.
  bit m_pregame, m_running, m_paused, m_between, m_over;
  int m_time, m_frac, m_qtr, m_horn;
  bit m_srst, m_off;

  function automatic vec_t mk(input logic r, s, w, p, x, input int sh, sl, wt,
                              input logic er, ep, es, eh, eo, input int q, secs);
    vec_t v;
    v.rst = r; v.start = s; v.whistle = w; v.poss = p; v.expired = x;
    v.sh = 4'(sh); v.sl = 4'(sl); v.wait_cycles = wt;
    v.e_run = er; v.e_pause = ep; v.e_srst = es; v.e_horn = eh; v.e_off = eo;
    v.e_q = q; v.e_secs = secs;
    return v;
  endfunction

  function automatic logic [23:0] exp_word(input logic er, ep, es, eh, eo, input int q, secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {er, ep, es, eh, eo, 3'(q), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [23:0] dut_word();
    return {run, shot_pause, shot_rst, horn, shot_off, quarter, min_h, min_l, sec_h, sec_l};
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got run/pause/srst/horn/off=%b q=%0d time=%h, expected run/pause/srst/horn/off=%b q=%0d time=%h",
               name, actual[23:19], actual[18:16], actual[15:0], expected[23:19], expected[18:16], expected[15:0]);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    rst = v.rst; start = v.start; whistle = v.whistle;
    possession = v.poss; shot_expired = v.expired;
    shot_h = v.sh; shot_l = v.sl;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; whistle = 1'b0; possession = 1'b0; shot_expired = 1'b0;
    repeat (v.wait_cycles) @(negedge clk);
    checkOutput(name, dut_word(), exp_word(v.e_run, v.e_pause, v.e_srst, v.e_horn, v.e_off, v.e_q, v.e_secs));
  endtask

  task automatic modelReset();
    m_pregame = 1; m_running = 0; m_paused = 0; m_between = 0; m_over = 0;
    m_time = QTR_MIN * 60; m_frac = 0; m_qtr = 1; m_horn = 0;
    m_srst = 1; m_off = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit go, tick, trig, pulse;
    int shot_val;
    shot_val = int'(shot_h) * 10 + int'(shot_l);
    m_off = (m_time < 60) && (m_time < shot_val);
    go    = start && !whistle;
    pulse = possession && (m_running || m_paused || m_between);
    trig  = 0;
    tick  = 0;
    if (m_pregame) begin
      if (go) begin m_pregame = 0; m_running = 1; end
    end else if (m_running) begin
      m_frac++;
      if (m_frac == CLK_DIV) begin m_frac = 0; m_time--; tick = 1; end
      if (tick && m_time == 0) begin
        trig = 1; m_running = 0;
        if (m_qtr < NUM_QTR) m_between = 1; else m_over = 1;
      end else if (whistle || shot_expired) begin
        m_running = 0; m_paused = 1;
        if (shot_expired) trig = 1;
      end
    end else if (m_paused) begin
      if (go) begin m_paused = 0; m_running = 1; end
    end else if (m_between) begin
      if (go) begin
        m_between = 0; m_running = 1; m_qtr++;
        m_time = QTR_MIN * 60; m_frac = 0; pulse = 1;
      end
    end
    if (trig) m_horn = HORN_LEN;
    else if (m_horn > 0) m_horn--;
    m_srst = m_pregame || m_over || pulse;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; whistle = 1'b0; possession = 1'b0;
    shot_expired = 1'b0; shot_h = 4'd0; shot_l = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset", dut_word(), exp_word(0, 1, 1, 0, 0, 1, 60));

    // Directed game flow:        r s w p x  sh sl wait  run pau srst horn off q secs
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 1, 60));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   3,  1, 0, 0, 0, 0, 1, 59));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  35,  1, 0, 0, 0, 0, 1, 50));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   0,  0, 1, 0, 0, 0, 1, 50));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  39,  0, 1, 0, 0, 0, 1, 50));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,   0,  0, 1, 0, 0, 0, 1, 50));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 1, 50));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1,  1, 0, 0, 0, 0, 1, 50));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 1, 49));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0,  0, 1, 0, 1, 0, 1, 49));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   6,  0, 1, 0, 1, 0, 1, 49));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  0, 1, 0, 0, 0, 1, 49));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0,  0, 1, 1, 0, 0, 1, 49));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  0, 1, 0, 0, 0, 1, 49));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 1, 49));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 4, 193,  1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   6,  0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  1, 0, 1, 0, 0, 2, 60));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 2, 60));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 237,  1, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  0, 1, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 1, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0,  0, 1, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,  10,  0, 1, 1, 0, 0, 2, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset out of FINAL, then shot_off around 00:20 and possession+whistle.
    applyStimulus(mk(1, 0, 0, 0, 0, 9, 9,   1,  0, 1, 1, 0, 0, 1, 60), "rst_from_final");
    applyStimulus(mk(0, 0, 0, 1, 0, 0, 0,   0,  0, 1, 1, 0, 0, 1, 60), "poss_in_idle");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 160,  1, 0, 0, 0, 0, 1, 20), "run_to_20");
    applyStimulus(mk(0, 0, 1, 1, 0, 2, 4,   0,  0, 1, 1, 0, 1, 1, 20), "whistle_poss_off24");
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 5,   0,  0, 1, 0, 0, 0, 1, 20), "off15");
    applyStimulus(mk(0, 0, 0, 0, 0, 2, 4,   0,  0, 1, 0, 0, 1, 1, 20), "off24_again");

    // Randomized play against the model, with occasional mid-game resets.
    for (int i = 0; i < 4000; i++) begin
      int v;
      rst          = (i == 0) || ($urandom_range(399) == 0);
      start        = ($urandom_range(7) == 0);
      whistle      = ($urandom_range(23) == 0);
      possession   = ($urandom_range(15) == 0);
      shot_expired = ($urandom_range(39) == 0);
      v            = $urandom_range(24);
      shot_h       = 4'(v / 10);
      shot_l       = 4'(v % 10);
      if (rst) modelReset();
      else modelStep();
      @(negedge clk);
      checkOutput($sformatf("random%0d", i), dut_word(),
                  exp_word(m_running, !m_running, m_srst, m_horn > 0, m_off, m_qtr, m_time));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/basketball_game_ctrl.md
Name: basketball_game_ctrl

Overview:
- Game-level sequencer sitting above the 24 s shot-clock block.
- Owns the period clock (mm:ss, BCD), the quarter count and the end-of-period horn.
- Drives the shot clock's reset/pause controls from referee inputs: start, whistle and possession change.
- Flags shot-clock-off when the game time remaining is below the shot time remaining.

Parameters:
- CLK_DIV, 50000000, clk cycles per game second; legal range 2 and up.
- QTR_MIN, 12, period length in minutes; legal range 1..99.
- NUM_QTR, 4, periods per game; legal range 1..7.
- HORN_LEN, 8, horn pulse length in clk cycles; legal range 1 and up.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse: start/resume play.
- whistle, input, 1, one-cycle pulse: stop play.
- possession, input, 1, one-cycle pulse: possession change.
- shot_expired, input, 1, shot clock alarm level (high = shot clock at 0).
- shot_h, input, 4, shot clock tens digit, BCD.
- shot_l, input, 4, shot clock units digit, BCD.
- shot_rst, output, 1, reload request to shot clock (high = reload 24).
- shot_pause, output, 1, hold request to shot clock (high = hold).
- run, output, 1, game clock running.
- min_h, output, 4, minutes tens digit, BCD.
- min_l, output, 4, minutes units digit, BCD.
- sec_h, output, 4, seconds tens digit, BCD (0..5).
- sec_l, output, 4, seconds units digit, BCD.
- quarter, output, 3, current period, 1..NUM_QTR.
- horn, output, 1, end-of-period / violation horn.
- shot_off, output, 1, shot clock display should be blanked.

Behaviour:
- All outputs are registered. Reset takes effect on the clk edge while rst=1.
- Reset values:
  - state IDLE, quarter=1, clock = QTR_MIN:00 in BCD.
  - shot_rst=1, shot_pause=1, run=0, horn=0, shot_off=0.
  - prescaler=0, horn counter=0.
- States:
  - IDLE: shot_rst=1. start -> RUN (shot_rst=0).
  - RUN: run=1, shot_pause=0. The prescaler counts 0..CLK_DIV-1; the wrap is a tick. Each tick decrements mm:ss in BCD (sec_l 0 -> 9 borrow; sec_h 0 -> 5 borrow; minute borrow likewise).
    - whistle -> STOP.
    - shot_expired=1 -> STOP and start horn.
    - The tick that produces 00:00 starts horn and goes to BREAK if quarter<NUM_QTR, else FINAL.
  - STOP: run=0, shot_pause=1. The prescaler holds its value, so a fractional second is kept. start -> RUN.
  - BREAK: shot_pause=1. start -> quarter+1, clock reloaded to QTR_MIN:00, prescaler=0, one-cycle shot_rst, -> RUN.
  - FINAL: shot_pause=1, shot_rst=1. start, whistle and possession are ignored. Only rst leaves FINAL.
- Control outputs: shot_pause = (state != RUN), registered, effective the cycle after the transition. run follows the same timing.
- possession pulse in RUN, STOP or BREAK -> shot_rst high for exactly one cycle; ignored in IDLE and FINAL.
- horn: high for HORN_LEN cycles from the cycle after the trigger. A retrigger while horn is high restarts the count.
- shot_off: registered; 1 when min_h=min_l=0 and {sec_h,sec_l} < {shot_h,shot_l}. Comparison is BCD and equals binary order on valid BCD. Otherwise 0.
- Simultaneous events:
  - start+whistle in the same cycle: whistle wins (RUN -> STOP; STOP stays STOP).
  - shot_expired and the 00:00 tick in the same cycle: the period-end path is taken, with a single horn.
  - possession with whistle: both act.
  - rst mid-operation: full reset on that edge, overriding everything.

Test Plan (CLK_DIV=4, QTR_MIN=1, NUM_QTR=2, HORN_LEN=8):
- rst for 2 cycles -> 01:00 (min_h=0, min_l=1, sec 0,0), quarter=1, shot_rst=1, shot_pause=1, run=0, horn=0.
- start pulse -> next cycle run=1, shot_pause=0, shot_rst=0; after 4 more cycles display 00:59; after 40 cycles 00:50.
- whistle at 00:50 -> shot_pause=1 next cycle; 40 idle cycles, display stays 00:50. start+whistle in the same cycle -> stays STOP. start alone -> resumes, and the next tick keeps the preserved prescaler phase.
- shot_expired=1 in RUN -> STOP; horn=1 for exactly 8 cycles. possession pulse -> shot_rst high for exactly 1 cycle.
- Run Q1 to 00:00 -> BREAK, horn 8 cycles, shot_pause=1. start -> quarter=2, display 01:00, one-cycle shot_rst, run=1. Q2 reaches 00:00 -> FINAL, shot_rst=1; later start/possession ignored; rst returns to IDLE.
- At 00:20 with shot_h=2, shot_l=4 -> shot_off=1. At 00:20 with shot 1,5 -> shot_off=0. At 01:00 with any shot value -> shot_off=0.
